// File: rtl/rgmii_tx_adapt.sv
// -----------------------------------------------------------------------------
// rgmii_tx_adapt
//
// Multi-channel RGMII transmit adapter. Each channel takes a MAC GMII transmit
// stream and produces the two half-cycle values (TXC, TXD nibble, TX_CTL) that
// drive the pad-level oddr primitives. Each channel runs at 10/100/1000 Mb/s
// with its own period counter. A speed change is picked up only at a period
// boundary, so TXC never produces a runt pulse.
//
// Parameters:
//   CHANNELS   number of independent transmit channels
//   DIV_100M   clk cycles per TXC period at 100M (>= 2)
//   DIV_10M    clk cycles per TXC period at 10M  (>= 2)
//
// Ports:
//   clk                 transmit clock, rising-edge logic
//   rst_n               asynchronous active-low reset
//   speed               per channel 2 bits: 00=10M, 01=100M, 1x=1000M
//   mac_gmii_txd        per channel 8-bit GMII data
//   mac_gmii_tx_en      per channel GMII enable
//   mac_gmii_tx_er      per channel GMII error
//   mac_gmii_tx_clk_en  per channel accept strobe (high in boundary cycles)
//   tx_clk_1/tx_clk_2   TXC value for first/second half of the clk cycle
//   txd_1/txd_2         data nibble for first/second half
//   tx_ctl_1/tx_ctl_2   TX_CTL for first/second half
//   speed_active        speed currently in effect per channel
// -----------------------------------------------------------------------------
module rgmii_tx_adapt #(
    parameter int CHANNELS = 1,
    parameter int DIV_100M = 5,
    parameter int DIV_10M  = 50
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [2*CHANNELS-1:0]   speed,
    input  logic [8*CHANNELS-1:0]   mac_gmii_txd,
    input  logic [CHANNELS-1:0]     mac_gmii_tx_en,
    input  logic [CHANNELS-1:0]     mac_gmii_tx_er,
    output logic [CHANNELS-1:0]     mac_gmii_tx_clk_en,
    output logic [CHANNELS-1:0]     tx_clk_1,
    output logic [CHANNELS-1:0]     tx_clk_2,
    output logic [4*CHANNELS-1:0]   txd_1,
    output logic [4*CHANNELS-1:0]   txd_2,
    output logic [CHANNELS-1:0]     tx_ctl_1,
    output logic [CHANNELS-1:0]     tx_ctl_2,
    output logic [2*CHANNELS-1:0]   speed_active
);

    localparam int DIV_MAX = (DIV_10M > DIV_100M) ? DIV_10M : DIV_100M;
    localparam int CW      = $clog2(DIV_MAX);
    // Two extra bits so that 2*c+1 never overflows when compared to DIV.
    localparam int XW      = CW + 2;

    localparam logic [XW-1:0] DIV_10M_X  = XW'(DIV_10M);
    localparam logic [XW-1:0] DIV_100M_X = XW'(DIV_100M);

    for (genvar ch = 0; ch < CHANNELS; ch++) begin : g_ch

        logic [1:0]    speed_q, speed_d;
        logic [CW-1:0] c_q, c_d;
        logic [7:0]    txd_q, txd_d;
        logic          en_q, en_d;
        logic          er_q, er_d;

        logic          gig;
        logic          boundary;
        logic [XW-1:0] div_x;
        logic [XW-1:0] c2_x;
        logic          hi_1;
        logic          hi_2;

        // Period bookkeeping: at a boundary the holds and the speed are
        // sampled and a new period starts at c=0; otherwise just count.
        always_comb begin
            gig      = speed_q[1];
            div_x    = speed_q[0] ? DIV_100M_X : DIV_10M_X;
            boundary = gig || ({2'b00, c_q} == (div_x - XW'(1)));

            speed_d = speed_q;
            c_d     = c_q + CW'(1);
            txd_d   = txd_q;
            en_d    = en_q;
            er_d    = er_q;

            if (boundary) begin
                speed_d = speed[2*ch +: 2];
                c_d     = '0;
                txd_d   = mac_gmii_txd[8*ch +: 8];
                en_d    = mac_gmii_tx_en[ch];
                er_d    = mac_gmii_tx_er[ch];
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                speed_q <= 2'b10;
                c_q     <= '0;
                txd_q   <= '0;
                en_q    <= 1'b0;
                er_q    <= 1'b0;
            end else begin
                speed_q <= speed_d;
                c_q     <= c_d;
                txd_q   <= txd_d;
                en_q    <= en_d;
                er_q    <= er_d;
            end
        end

        // Half-cycle TXC decode for 10/100: the half with index 2c (first)
        // or 2c+1 (second) is high while it lies in the first half of the
        // 2*DIV half-cycle period, giving 50% duty even for odd DIV.
        always_comb begin
            c2_x = {1'b0, c_q, 1'b0};
            hi_1 = (c2_x < div_x);
            hi_2 = ((c2_x | XW'(1)) < div_x);
        end

        // Strobe and TXC are forced low while reset is asserted; the data
        // and ctl outputs are already zero from the cleared holds.
        assign mac_gmii_tx_clk_en[ch] = rst_n & boundary;
        assign tx_clk_1[ch]           = rst_n & (gig | hi_1);
        assign tx_clk_2[ch]           = rst_n & ~gig & hi_2;

        assign txd_1[4*ch +: 4]       = txd_q[3:0];
        assign txd_2[4*ch +: 4]       = gig ? txd_q[7:4] : txd_q[3:0];

        // RGMII TX_CTL: TX_EN on the TXC-high half, TX_EN^TX_ER on the low half.
        assign tx_ctl_1[ch]           = (gig | hi_1)  ? en_q : (en_q ^ er_q);
        assign tx_ctl_2[ch]           = (~gig & hi_2) ? en_q : (en_q ^ er_q);

        assign speed_active[2*ch +: 2] = speed_q;

    end

endmodule

// File: tb/tb_rgmii_tx_adapt.sv
module tb_rgmii_tx_adapt;

    localparam int CH = 2;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [2*CH-1:0] speed;
    logic [8*CH-1:0] mac_gmii_txd;
    logic [CH-1:0]   mac_gmii_tx_en;
    logic [CH-1:0]   mac_gmii_tx_er;
    logic [CH-1:0]   mac_gmii_tx_clk_en;
    logic [CH-1:0]   tx_clk_1, tx_clk_2;
    logic [4*CH-1:0] txd_1, txd_2;
    logic [CH-1:0]   tx_ctl_1, tx_ctl_2;
    logic [2*CH-1:0] speed_active;

    rgmii_tx_adapt #(
        .CHANNELS (CH),
        .DIV_100M (5),
        .DIV_10M  (50)
    ) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .speed              (speed),
        .mac_gmii_txd       (mac_gmii_txd),
        .mac_gmii_tx_en     (mac_gmii_tx_en),
        .mac_gmii_tx_er     (mac_gmii_tx_er),
        .mac_gmii_tx_clk_en (mac_gmii_tx_clk_en),
        .tx_clk_1           (tx_clk_1),
        .tx_clk_2           (tx_clk_2),
        .txd_1              (txd_1),
        .txd_2              (txd_2),
        .tx_ctl_1           (tx_ctl_1),
        .tx_ctl_2           (tx_ctl_2),
        .speed_active       (speed_active)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       clk_en;
        logic       clk1;
        logic       clk2;
        logic [3:0] txd1;
        logic [3:0] txd2;
        logic       ctl1;
        logic       ctl2;
        logic [1:0] spd;
    } ch_exp_t;

    typedef struct packed {
        ch_exp_t c1;
        ch_exp_t c0;
    } exp_t;

    exp_t q[$];
    exp_t mon_e;
    int   checks = 0;
    int   passed = 0;

    localparam logic [7:0] PD [4] = '{8'h37, 8'h9E, 8'h61, 8'h4C};
    localparam logic       PE [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
    localparam logic       PR [4] = '{1'b0, 1'b1, 1'b1, 1'b1};

    // ---------------- expected-value helpers ----------------
    function automatic ch_exp_t gig_exp(input logic [7:0] d, input logic e,
                                        input logic r, input logic [1:0] s);
        ch_exp_t x;
        x.clk_en = 1'b1;
        x.clk1   = 1'b1;
        x.clk2   = 1'b0;
        x.txd1   = d[3:0];
        x.txd2   = d[7:4];
        x.ctl1   = e;
        x.ctl2   = e ^ r;
        x.spd    = s;
        return x;
    endfunction

    function automatic ch_exp_t slow_exp(input int div, input int c,
                                         input logic [7:0] d, input logic e,
                                         input logic r, input logic [1:0] s);
        ch_exp_t x;
        x.clk_en = (c == div - 1);
        x.clk1   = (2 * c < div);
        x.clk2   = (2 * c + 1 < div);
        x.txd1   = d[3:0];
        x.txd2   = d[3:0];
        x.ctl1   = x.clk1 ? e : (e ^ r);
        x.ctl2   = x.clk2 ? e : (e ^ r);
        x.spd    = s;
        return x;
    endfunction

    function automatic ch_exp_t reset_exp();
        ch_exp_t x;
        x     = '0;
        x.spd = 2'b10;
        return x;
    endfunction

    // First cycle after release: 1000M boundary with cleared holds.
    function automatic ch_exp_t post_rel_exp();
        ch_exp_t x;
        x        = '0;
        x.clk_en = 1'b1;
        x.clk1   = 1'b1;
        x.spd    = 2'b10;
        return x;
    endfunction

    // ---------------- monitor ----------------
    task automatic chk(input string nm, input int ch,
                       input logic [3:0] act, input logic [3:0] req);
        checks++;
        if (act === req) passed++;
        else $display("FAIL %s ch%0d at %0t: got %h required %h", nm, ch, $time, act, req);
    endtask

    task automatic check_ch(input int ch, input ch_exp_t e);
        chk("clk_en", ch, {3'b0, mac_gmii_tx_clk_en[ch]}, {3'b0, e.clk_en});
        chk("tx_clk_1", ch, {3'b0, tx_clk_1[ch]}, {3'b0, e.clk1});
        chk("tx_clk_2", ch, {3'b0, tx_clk_2[ch]}, {3'b0, e.clk2});
        chk("txd_1", ch, txd_1[4*ch +: 4], e.txd1);
        chk("txd_2", ch, txd_2[4*ch +: 4], e.txd2);
        chk("tx_ctl_1", ch, {3'b0, tx_ctl_1[ch]}, {3'b0, e.ctl1});
        chk("tx_ctl_2", ch, {3'b0, tx_ctl_2[ch]}, {3'b0, e.ctl2});
        chk("speed_active", ch, {2'b0, speed_active[2*ch +: 2]}, {2'b0, e.spd});
    endtask

    always @(negedge clk) begin
        if (q.size() > 0) begin
            mon_e = q.pop_front();
            check_ch(0, mon_e.c0);
            check_ch(1, mon_e.c1);
        end
    end

    // ---------------- stimulus ----------------
    task automatic push2(input ch_exp_t e0, input ch_exp_t e1);
        exp_t r;
        r.c0 = e0;
        r.c1 = e1;
        q.push_back(r);
    endtask

    task automatic set0(input logic [7:0] d, input logic e, input logic r);
        mac_gmii_txd[7:0] = d;
        mac_gmii_tx_en[0] = e;
        mac_gmii_tx_er[0] = r;
    endtask

    // One clk cycle; ch1 stays at 1000M (speed 11) with changing data.
    task automatic tick(input ch_exp_t e0);
        ch_exp_t e1;
        e1 = gig_exp(mac_gmii_txd[15:8], mac_gmii_tx_en[1], mac_gmii_tx_er[1], speed[3:2]);
        @(posedge clk);
        #1;
        push2(e0, e1);
        mac_gmii_txd[15:8] = mac_gmii_txd[15:8] + 8'h3B;
        mac_gmii_tx_en[1]  = ~mac_gmii_tx_en[1];
        mac_gmii_tx_er[1]  = mac_gmii_txd[8];
    endtask

    initial begin
        speed          = 4'b1110;
        mac_gmii_txd   = {8'h3C, 8'hA5};
        mac_gmii_tx_en = 2'b11;
        mac_gmii_tx_er = 2'b10;

        // Reset held
        repeat (2) begin
            @(posedge clk);
            #1;
            push2(reset_exp(), reset_exp());
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        push2(post_rel_exp(), post_rel_exp());

        // 1000M, one-cycle latency
        tick(gig_exp(8'hA5, 1'b1, 1'b0, 2'b10));
        set0(8'h5A, 1'b1, 1'b0); tick(gig_exp(8'h5A, 1'b1, 1'b0, 2'b10));
        set0(8'h00, 1'b0, 1'b0); tick(gig_exp(8'h00, 1'b0, 1'b0, 2'b10));
        set0(8'hFF, 1'b1, 1'b1); tick(gig_exp(8'hFF, 1'b1, 1'b1, 2'b10));
        set0(8'hC3, 1'b0, 1'b1); tick(gig_exp(8'hC3, 1'b0, 1'b1, 2'b10));

        // 100M: three periods; data and speed changes mid-period are deferred
        set0(PD[0], PE[0], PR[0]);
        speed[1:0] = 2'b01;
        for (int p = 0; p < 3; p++) begin
            for (int c = 0; c < 5; c++) begin
                tick(slow_exp(5, c, PD[p], PE[p], PR[p], 2'b01));
                if (c == 0) begin
                    set0(PD[p+1], PE[p+1], PR[p+1]);
                    if (p == 2) speed[1:0] = 2'b00;
                end
            end
        end

        // 10M with en=1, er=1
        for (int c = 0; c < 50; c++) begin
            tick(slow_exp(50, c, 8'h4C, 1'b1, 1'b1, 2'b00));
            if (c == 0) set0(8'h61, 1'b1, 1'b0);
        end

        // 10M period with a switch to 1000M requested at c=10
        for (int c = 0; c < 50; c++) begin
            tick(slow_exp(50, c, 8'h61, 1'b1, 1'b0, 2'b00));
            if (c == 10) begin
                speed[1:0] = 2'b10;
                set0(8'hD2, 1'b1, 1'b0);
            end
        end
        tick(gig_exp(8'hD2, 1'b1, 1'b0, 2'b10));

        // 100M then reset asserted at c=2
        set0(8'hB7, 1'b1, 1'b0);
        speed[1:0] = 2'b01;
        tick(slow_exp(5, 0, 8'hB7, 1'b1, 1'b0, 2'b01));
        tick(slow_exp(5, 1, 8'hB7, 1'b1, 1'b0, 2'b01));
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        push2(reset_exp(), reset_exp());
        @(posedge clk);
        #1;
        push2(reset_exp(), reset_exp());
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        push2(post_rel_exp(), post_rel_exp());

        // Clean 100M periods after release
        for (int p = 0; p < 2; p++) begin
            for (int c = 0; c < 5; c++) begin
                tick(slow_exp(5, c, (p == 0) ? 8'hB7 : 8'h5E, 1'b1, 1'b0, 2'b01));
                if (p == 0 && c == 0) set0(8'h5E, 1'b1, 1'b0);
            end
        end

        for (int i = 0; i < 10 && q.size() != 0; i++) @(negedge clk);
        @(negedge clk);
        if (q.size() != 0) begin
            checks++;
            $display("FAIL drain: %0d expected entries left, required 0", q.size());
        end
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1);
    end

endmodule
